// File: rtl/tinyarch_seq.sv
// tinyarch program sequencer: PC, start/done handshake, skips, jumps,
// call/return stack, stack fault detection and a cycle budget.
module tinyarch_seq #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int SKIP_W      = 3,
  parameter int STACK_DEPTH = 4,
  parameter int START_ADDR  = 0,
  parameter int CYC_W       = 24,
  parameter int MAX_CYCLES  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exit,
  input  logic [2:0]        jump_mode,
  input  logic [DATA_W-1:0] cond_value,
  input  logic [SKIP_W-1:0] skip,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [CYC_W-1:0]  cycle_count
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STK_N = 1 << IDX_W;

  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(START_ADDR);
  localparam logic [CYC_W-1:0]  CYC_LIM = CYC_W'(MAX_CYCLES - 1);
  localparam bit                TMO_EN  = (MAX_CYCLES != 0);

  localparam logic [2:0] JM_SKNZ = 3'd1;
  localparam logic [2:0] JM_SKZ  = 3'd2;
  localparam logic [2:0] JM_JUMP = 3'd3;
  localparam logic [2:0] JM_CALL = 3'd4;
  localparam logic [2:0] JM_RET  = 3'd5;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_UNF  = 2'd2;
  localparam logic [1:0] FC_TMO  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        fc_q, fc_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] stack_q [STK_N];
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [ADDR_W-1:0] pc_inc, pc_skip, nxt_pc;
  logic              push, ovf, unf, tmo;

  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign pc_skip  = pc_q + ADDR_W'(skip) + ADDR_W'(2);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    push    = 1'b0;
    nxt_pc  = pc_inc;
    ovf     = 1'b0;
    unf     = 1'b0;
    tmo     = TMO_EN && (cnt_q == CYC_LIM);

    case (jump_mode)
      JM_SKNZ: if (|cond_value) nxt_pc = pc_skip;
      JM_SKZ:  if (cond_value == '0) nxt_pc = pc_skip;
      JM_JUMP: nxt_pc = jump_addr;
      JM_CALL: begin
        nxt_pc = jump_addr;
        ovf    = (sp_q == SP_FULL);
      end
      JM_RET: begin
        nxt_pc = stack_q[pop_idx];
        unf    = (sp_q == '0);
      end
      default: ;
    endcase

    if (start && !exit) begin
      state_d = S_RUN;
      pc_d    = PC_RST;
      sp_d    = '0;
      cnt_d   = '0;
      fc_d    = FC_NONE;
    end else if (state_q == S_RUN) begin
      if (exit) begin
        state_d = S_DONE;
      end else if (ovf || unf || tmo) begin
        // the faulting instruction does not retire: pc and count hold
        state_d = S_FAULT;
        fc_d    = ovf ? FC_OVF : (unf ? FC_UNF : FC_TMO);
      end else begin
        pc_d = nxt_pc;
        if (cnt_q != '1) cnt_d = cnt_q + CYC_W'(1);
        if (jump_mode == JM_CALL) begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end else if (jump_mode == JM_RET) begin
          sp_d = sp_q - SP_W'(1);
        end
      end
    end

    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE) || (state_d == S_FAULT);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      sp_q      <= '0;
      cnt_q     <= '0;
      fc_q      <= FC_NONE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      fc_q      <= fc_d;
      running_q <= running_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  assign pc          = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_code  = fc_q;
  assign cycle_count = cnt_q;

endmodule
